// File: rtl/bus_pkg.sv
// Shared definitions for the bus fabric: FSM state encoding, default error word, slave-count limit.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_WORD_DEF = 32'hDEADBEEF;
  localparam int          NS_MAX       = 8;

endpackage

// File: rtl/bus_decode.sv
// Address decoder: one-hot slave select with lowest-index priority on overlapping windows.
module bus_decode #(
  parameter int AW = 16,
  parameter int NS = 4
) (
  input  logic [AW-1:0]    addr,
  input  logic [NS*AW-1:0] base,
  input  logic [NS*AW-1:0] mask,
  output logic [NS-1:0]    sel,
  output logic             hit
);

  // Walk from the top so the lowest matching index is the one left standing.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((addr & mask[i*AW +: AW]) == base[i*AW +: AW]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, NS-slave bus fabric with one outstanding read.
// Define BUS_FABRIC_TIMEOUT_EN to bound the read wait to TIMEOUT cycles.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                W        = 32,
  parameter int                AW       = 16,
  parameter int                NS       = 4,
  parameter logic [NS*AW-1:0]  BASE     = {NS{AW'(0)}},
  parameter logic [NS*AW-1:0]  MASK     = {NS{AW'(0)}},
  parameter int                TIMEOUT  = 15,
  parameter logic [W-1:0]      ERR_WORD = W'(ERR_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     m_addr,
  input  logic              m_ren,
  input  logic              m_wen,
  input  logic [W-1:0]      m_wdata,
  input  logic [W/8-1:0]    m_wmask,
  output logic [W-1:0]      m_rdata,
  output logic              m_rd_valid,
  output logic              m_busy,
  output logic              m_err,
  output logic [AW-1:0]     s_addr,
  output logic [W-1:0]      s_wdata,
  output logic [W/8-1:0]    s_wmask,
  output logic [NS-1:0]     s_ren,
  output logic [NS-1:0]     s_wen,
  input  logic [NS*W-1:0]   s_rdata,
  input  logic [NS-1:0]     s_rd_valid
);

  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt, sel_idx;
  logic [W-1:0]    rdata_nxt;
  logic            rd_valid_nxt, err_nxt;
  logic [NS-1:0]   sel;
  logic            hit, wr, timed_out;

  bus_decode #(.AW(AW), .NS(NS)) u_decode (
    .addr (m_addr),
    .base (BASE),
    .mask (MASK),
    .sel  (sel),
    .hit  (hit)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NS; i++)
      if (sel[i]) sel_idx = IW'(i);
  end

  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_wmask = m_wmask;
  assign m_busy  = (state != IDLE);

  // A simultaneous read and write is treated as a read only.
  assign wr    = m_wen & ~m_ren;
  assign s_ren = m_busy ? '0 : (sel & {NS{m_ren}});
  assign s_wen = sel & {NS{wr}};

`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nxt;

  assign cnt_nxt   = (state == WAIT) ? cnt + CW'(1) : '0;
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    rdata_nxt    = m_rdata;
    rd_valid_nxt = 1'b0;
    err_nxt      = wr & ~hit;
    case (state)
      IDLE: begin
        if (m_ren) begin
          idx_nxt   = sel_idx;
          state_nxt = hit ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (s_rd_valid[idx]) begin
          rdata_nxt    = s_rdata[idx*W +: W];
          rd_valid_nxt = 1'b1;
          state_nxt    = IDLE;
        end else if (timed_out) begin
          rdata_nxt    = ERR_WORD;
          rd_valid_nxt = 1'b1;
          err_nxt      = 1'b1;
          state_nxt    = IDLE;
        end
      end
      RESP: begin
        rdata_nxt    = '0;
        rd_valid_nxt = 1'b1;
        err_nxt      = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      m_rdata    <= '0;
      m_rd_valid <= 1'b0;
      m_err      <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      m_rdata    <= rdata_nxt;
      m_rd_valid <= rd_valid_nxt;
      m_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed self-checking bench for bus_fabric (4 slaves, TIMEOUT = 15).
module tb_bus_fabric;

  localparam int W  = 32;
  localparam int AW = 16;
  localparam int NS = 4;
  localparam logic [NS*AW-1:0] BASE = {16'h8000, 16'h5000, 16'h4000, 16'h0000};
  localparam logic [NS*AW-1:0] MASK = {16'h8000, 16'hF000, 16'hF000, 16'hC000};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     m_addr = '0;
  logic              m_ren = 1'b0, m_wen = 1'b0;
  logic [W-1:0]      m_wdata = '0;
  logic [W/8-1:0]    m_wmask = '0;
  logic [W-1:0]      m_rdata;
  logic              m_rd_valid, m_busy, m_err;
  logic [AW-1:0]     s_addr;
  logic [W-1:0]      s_wdata;
  logic [W/8-1:0]    s_wmask;
  logic [NS-1:0]     s_ren, s_wen;
  logic [NS*W-1:0]   s_rdata = '0;
  logic [NS-1:0]     s_rd_valid = '0;

  int tests = 0;
  int fails = 0;

  bus_fabric #(.W(W), .AW(AW), .NS(NS), .BASE(BASE), .MASK(MASK), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rdata(m_rdata), .m_rd_valid(m_rd_valid), .m_busy(m_busy), .m_err(m_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_ren(s_ren), .s_wen(s_wen), .s_rdata(s_rdata), .s_rd_valid(s_rd_valid)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if ({m_busy, m_rd_valid, m_err} !== 3'b000 || m_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: busy/valid/err=%b rdata=%h, want 000 / 00000000",
               {m_busy, m_rd_valid, m_err}, m_rdata);
    end
  endtask

  task automatic test_read_basic();
    m_addr = 16'h9004; m_ren = 1'b1; m_wdata = 32'hA5A5_0001; m_wmask = 4'b1010;
    #1;
    tests++;
    if (s_ren !== 4'b1000 || s_addr !== 16'h9004 || s_wdata !== 32'hA5A5_0001 || s_wmask !== 4'b1010) begin
      fails++;
      $display("FAIL read_decode: s_ren=%b s_addr=%h s_wdata=%h s_wmask=%b, want 1000 9004 a5a50001 1010",
               s_ren, s_addr, s_wdata, s_wmask);
    end
    tick();
    m_ren = 1'b0;
    tests++;
    if (m_busy !== 1'b1) begin
      fails++;
      $display("FAIL read_busy: m_busy=%b, want 1", m_busy);
    end
    tick();
    s_rd_valid = 4'b1000; s_rdata[3*W +: W] = 32'h1234_5678;
    tests++;
    if (m_rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_early: m_rd_valid=%b, want 0", m_rd_valid);
    end
    tick();
    s_rd_valid = '0;
    tests++;
    if (m_rd_valid !== 1'b1 || m_rdata !== 32'h1234_5678 || m_busy !== 1'b0 || m_err !== 1'b0) begin
      fails++;
      $display("FAIL read_resp: valid=%b rdata=%h busy=%b err=%b, want 1 12345678 0 0",
               m_rd_valid, m_rdata, m_busy, m_err);
    end
    tick();
    tests++;
    if (m_rd_valid !== 1'b0 || m_rdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL read_hold: valid=%b rdata=%h, want 0 12345678", m_rd_valid, m_rdata);
    end
  endtask

  task automatic test_latched_index();
    m_addr = 16'h0010; m_ren = 1'b1;
    #1;
    tests++;
    if (s_ren !== 4'b0001) begin
      fails++;
      $display("FAIL latch_decode: s_ren=%b, want 0001", s_ren);
    end
    tick();
    m_addr = 16'h4000; m_ren = 1'b0;
    s_rd_valid = 4'b0010; s_rdata[1*W +: W] = 32'hAAAA_1111;
    tick();
    tests++;
    if (m_rd_valid !== 1'b0 || m_busy !== 1'b1) begin
      fails++;
      $display("FAIL latch_ignore_other: valid=%b busy=%b, want 0 1", m_rd_valid, m_busy);
    end
    s_rd_valid = 4'b0011; s_rdata[0*W +: W] = 32'h0BAD_0010;
    tick();
    s_rd_valid = '0;
    tests++;
    if (m_rd_valid !== 1'b1 || m_rdata !== 32'h0BAD_0010) begin
      fails++;
      $display("FAIL latch_data: valid=%b rdata=%h, want 1 0bad0010", m_rd_valid, m_rdata);
    end
    tick();
  endtask

  task automatic test_unmapped();
    m_addr = 16'h6000; m_ren = 1'b1;
    #1;
    tests++;
    if (s_ren !== 4'b0000) begin
      fails++;
      $display("FAIL unmapped_rd_strobe: s_ren=%b, want 0000", s_ren);
    end
    tick();
    m_ren = 1'b0;
    tests++;
    if (m_busy !== 1'b1 || m_rd_valid !== 1'b0 || m_err !== 1'b0) begin
      fails++;
      $display("FAIL unmapped_rd_cycle1: busy=%b valid=%b err=%b, want 1 0 0", m_busy, m_rd_valid, m_err);
    end
    tick();
    tests++;
    if (m_rd_valid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
      fails++;
      $display("FAIL unmapped_rd_resp: valid=%b err=%b rdata=%h, want 1 1 00000000", m_rd_valid, m_err, m_rdata);
    end
    tick();
    tests++;
    if (m_rd_valid !== 1'b0 || m_err !== 1'b0 || m_busy !== 1'b0) begin
      fails++;
      $display("FAIL unmapped_rd_after: valid=%b err=%b busy=%b, want 0 0 0", m_rd_valid, m_err, m_busy);
    end
    m_wen = 1'b1; m_wdata = 32'h5555_AAAA;
    #1;
    tests++;
    if (s_wen !== 4'b0000) begin
      fails++;
      $display("FAIL unmapped_wr_strobe: s_wen=%b, want 0000", s_wen);
    end
    tick();
    m_wen = 1'b0;
    tests++;
    if (m_err !== 1'b1 || m_rd_valid !== 1'b0 || m_busy !== 1'b0) begin
      fails++;
      $display("FAIL unmapped_wr_err: err=%b valid=%b busy=%b, want 1 0 0", m_err, m_rd_valid, m_busy);
    end
    tick();
    tests++;
    if (m_err !== 1'b0) begin
      fails++;
      $display("FAIL unmapped_wr_pulse: err=%b, want 0", m_err);
    end
  endtask

  task automatic test_busy();
    m_addr = 16'h5000; m_ren = 1'b1;
    #1;
    tests++;
    if (s_ren !== 4'b0100) begin
      fails++;
      $display("FAIL busy_first_read: s_ren=%b, want 0100", s_ren);
    end
    tick();
    m_addr = 16'h0010;
    #1;
    tests++;
    if (s_ren !== 4'b0000) begin
      fails++;
      $display("FAIL busy_read_blocked: s_ren=%b, want 0000", s_ren);
    end
    tick();
    m_ren = 1'b0; m_wen = 1'b1; m_addr = 16'h4000;
    #1;
    tests++;
    if (s_wen !== 4'b0010 || s_ren !== 4'b0000) begin
      fails++;
      $display("FAIL busy_write_fwd: s_wen=%b s_ren=%b, want 0010 0000", s_wen, s_ren);
    end
    tick();
    m_wen = 1'b0;
    s_rd_valid = 4'b0101; s_rdata[2*W +: W] = 32'h2222_0000; s_rdata[0*W +: W] = 32'h0000_DEAD;
    tick();
    s_rd_valid = '0;
    tests++;
    if (m_rd_valid !== 1'b1 || m_rdata !== 32'h2222_0000 || m_err !== 1'b0) begin
      fails++;
      $display("FAIL busy_complete: valid=%b rdata=%h err=%b, want 1 22220000 0", m_rd_valid, m_rdata, m_err);
    end
    tick();
    tests++;
    if (m_rd_valid !== 1'b0 || m_busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_no_ghost: valid=%b busy=%b, want 0 0", m_rd_valid, m_busy);
    end
  endtask

  task automatic test_read_write_both();
    m_addr = 16'h4000; m_ren = 1'b1; m_wen = 1'b1;
    #1;
    tests++;
    if (s_ren !== 4'b0010 || s_wen !== 4'b0000) begin
      fails++;
      $display("FAIL rw_both: s_ren=%b s_wen=%b, want 0010 0000", s_ren, s_wen);
    end
    tick();
    m_ren = 1'b0; m_wen = 1'b0;
    s_rd_valid = 4'b0010; s_rdata[1*W +: W] = 32'h4444_4444;
    tick();
    s_rd_valid = '0;
    tests++;
    if (m_rd_valid !== 1'b1 || m_rdata !== 32'h4444_4444) begin
      fails++;
      $display("FAIL rw_both_resp: valid=%b rdata=%h, want 1 44444444", m_rd_valid, m_rdata);
    end
    tick();
  endtask

  task automatic test_wait_bound();
    m_addr = 16'h9004; m_ren = 1'b1;
    tick();
    m_ren = 1'b0;
    // WAIT occupies the 15 cycles after the request; no response may appear within them.
    for (int k = 1; k <= 15; k++) begin
      tests++;
      if (m_rd_valid !== 1'b0 || m_busy !== 1'b1) begin
        fails++;
        $display("FAIL wait_cycle_%0d: valid=%b busy=%b, want 0 1", k, m_rd_valid, m_busy);
      end
      tick();
    end
`ifdef BUS_FABRIC_TIMEOUT_EN
    tests++;
    if (m_rd_valid !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'hDEADBEEF || m_busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_resp: valid=%b err=%b rdata=%h busy=%b, want 1 1 deadbeef 0",
               m_rd_valid, m_err, m_rdata, m_busy);
    end
    tick();
    tests++;
    if (m_rd_valid !== 1'b0 || m_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: valid=%b err=%b, want 0 0", m_rd_valid, m_err);
    end
`else
    for (int k = 0; k < 25; k++) tick();
    tests++;
    if (m_rd_valid !== 1'b0 || m_busy !== 1'b1) begin
      fails++;
      $display("FAIL no_timeout_wait: valid=%b busy=%b, want 0 1", m_rd_valid, m_busy);
    end
    s_rd_valid = 4'b1000; s_rdata[3*W +: W] = 32'h7777_0003;
    tick();
    s_rd_valid = '0;
    tests++;
    if (m_rd_valid !== 1'b1 || m_rdata !== 32'h7777_0003) begin
      fails++;
      $display("FAIL no_timeout_late_resp: valid=%b rdata=%h, want 1 77770003", m_rd_valid, m_rdata);
    end
`endif
    tick();
  endtask

  task automatic test_reset_in_wait();
    m_addr = 16'h9004; m_ren = 1'b1;
    tick();
    m_ren = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (m_busy !== 1'b0 || m_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_async: busy=%b rdata=%h, want 0 00000000", m_busy, m_rdata);
    end
    tick();
    rst_n = 1'b1;
    tick();
    s_rd_valid = 4'b1000; s_rdata[3*W +: W] = 32'hBBBB_CCCC;
    tick();
    s_rd_valid = '0;
    tests++;
    if (m_rd_valid !== 1'b0 || m_busy !== 1'b0 || m_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_late_valid: valid=%b busy=%b rdata=%h, want 0 0 00000000", m_rd_valid, m_busy, m_rdata);
    end
    tick();
    tests++;
    if (m_rd_valid !== 1'b0 || m_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_after: valid=%b err=%b, want 0 0", m_rd_valid, m_err);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_read_basic();
    test_latched_index();
    test_unmapped();
    test_busy();
    test_read_write_both();
    test_wait_bound();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
